// File: rtl/alu_op_sequencer_if.sv
// Bundle of instruction-input, ALU-drive and writeback signals around the ALU op sequencer.
// The slave modport is the sequencer's view; master is the environment driving it.
interface alu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_instr;
    logic        alu_en;
    logic [2:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        wb_valid;
    logic [1:0]  wb_dst;
    logic [3:0]  wb_data;
    logic        flag_c;
    logic        flag_z;
    logic        busy;

    modport slave (
        input  in_valid, in_instr, alu_result, alu_carry, alu_zero,
        output in_ready, alu_en, alu_op, alu_a, alu_b,
               wb_valid, wb_dst, wb_data, flag_c, flag_z, busy
    );

    modport master (
        output in_valid, in_instr, alu_result, alu_carry, alu_zero,
        input  in_ready, alu_en, alu_op, alu_a, alu_b,
               wb_valid, wb_dst, wb_data, flag_c, flag_z, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers 13-bit instructions, executes loads locally and sequences ALU ops through an
// external registered 4-bit ALU (IDLE -> ISSUE -> CAPTURE), reporting each retirement once.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [12:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [1:0] r_state;
    logic [2:0] r_op;
    logic [1:0] r_dst;
    logic [1:0] r_srca;
    logic [1:0] r_srcb;
    logic [3:0] r_regs [4];

    logic       r_wb_valid;
    logic [1:0] r_wb_dst;
    logic [3:0] r_wb_data;
    logic       r_flag_c;
    logic       r_flag_z;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [12:0] w_head;
    logic        w_issue;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    // Ready is held low through reset so nothing is accepted into a buffer being cleared.
    assign bus.in_ready = ~rst & ~w_full;
    assign w_push  = bus.in_valid & bus.in_ready;
    assign w_pop   = (r_state == IDLE) & ~w_empty;
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_issue = (r_state == ISSUE);

    // NOTE: the storage array has no reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_dst      <= '0;
            r_srca     <= '0;
            r_srcb     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_dst   <= '0;
            r_wb_data  <= '0;
            r_flag_c   <= 1'b0;
            r_flag_z   <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        if (w_head[12]) begin
                            r_regs[w_head[8:7]] <= w_head[3:0];
                            r_wb_valid          <= 1'b1;
                            r_wb_dst            <= w_head[8:7];
                            r_wb_data           <= w_head[3:0];
                        end else begin
                            r_op    <= w_head[11:9];
                            r_dst   <= w_head[8:7];
                            r_srca  <= w_head[6:5];
                            r_srcb  <= w_head[4:3];
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: r_state <= CAPTURE;
                CAPTURE: begin
                    r_regs[r_dst] <= bus.alu_result;
                    r_flag_c      <= bus.alu_carry;
                    r_flag_z      <= bus.alu_zero;
                    r_wb_valid    <= 1'b1;
                    r_wb_dst      <= r_dst;
                    r_wb_data     <= bus.alu_result;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operands are read from the register file during ISSUE, so a prior writeback is always visible.
    assign bus.alu_en   = w_issue;
    assign bus.alu_op   = w_issue ? r_op : 3'd0;
    assign bus.alu_a    = w_issue ? r_regs[r_srca] : 4'd0;
    assign bus.alu_b    = w_issue ? r_regs[r_srcb] : 4'd0;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_dst   = r_wb_dst;
    assign bus.wb_data  = r_wb_data;
    assign bus.flag_c   = r_flag_c;
    assign bus.flag_z   = r_flag_z;
    assign bus.busy     = (r_state != IDLE) | ~w_empty;
endmodule
